// File: rtl/uart_pkg.sv
// UART receiver shared types.
// State encoding and baud defaults.
package uart_pkg;

  typedef enum logic [2:0] {
    WAIT_HIGH,
    IDLE,
    START,
    DATA,
    STOP
  } uart_rx_state_t;

  localparam int UART_CLKS_PER_BIT_100M_115200 = 868;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop bit synchroniser, resets to 1.
// Used for rx and later for button inputs.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  // shift the async input through the flop chain
  always_ff @(posedge clk) begin
    if (rst) ff <= '1;
    else     ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver for the keyboard link.
// Drops glitch starts and bad stop bits.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_100M_115200,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       framing_error,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_M1  = CW'(CLKS_PER_BIT - 1);

  uart_rx_state_t state, state_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic [2:0]     idx, idx_n;
  logic [7:0]     shift, shift_n;
  logic [7:0]     data_n;
  logic           dv_n, fe_n;
  logic           rx_s;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  // state, counters and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= WAIT_HIGH;
      cnt           <= '0;
      idx           <= '0;
      shift         <= '0;
      data          <= '0;
      data_valid    <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      idx           <= idx_n;
      shift         <= shift_n;
      data          <= data_n;
      data_valid    <= dv_n;
      framing_error <= fe_n;
    end
  end

  // next-state, bit sampling and pulse generation
  always_comb begin
    state_n = state;
    cnt_n   = cnt + CW'(1);
    idx_n   = idx;
    shift_n = shift;
    data_n  = data;
    dv_n    = 1'b0;
    fe_n    = 1'b0;
    unique case (state)
      WAIT_HIGH: begin
        // the synchroniser powers up high, so wait until it has
        // flushed and the line is still high before arming
        if (!rx_s) begin
          cnt_n = '0;
        end else if (int'(cnt) >= SYNC_STAGES) begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      end
      IDLE: begin
        if (!rx_s) begin
          state_n = START;
          cnt_n   = '0;
        end
      end
      START: begin
        if (cnt == HALF_M1) begin
          cnt_n = '0;
          if (rx_s) begin
            state_n = IDLE;
          end else begin
            state_n = DATA;
            idx_n   = '0;
          end
        end
      end
      DATA: begin
        if (cnt == BIT_M1) begin
          cnt_n   = '0;
          shift_n = {rx_s, shift[7:1]};
          idx_n   = idx + 3'd1;
          if (idx == 3'd7) state_n = STOP;
        end
      end
      STOP: begin
        if (cnt == BIT_M1) begin
          cnt_n = '0;
          if (rx_s) begin
            data_n  = shift;
            dv_n    = 1'b1;
            state_n = IDLE;
          end else begin
            fe_n    = 1'b1;
            state_n = WAIT_HIGH;
          end
        end
      end
      default: state_n = WAIT_HIGH;
    endcase
  end

  assign busy = (state == START) || (state == DATA) || (state == STOP);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx.
// Table vectors, corner sequences, random frames.
module tb_uart_rx;

  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;
  localparam int SS   = 2;
  // pin edge to data_valid cycle
  localparam int LAT  = SS + HALF + 9 * CPB + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] data;
  logic       data_valid;
  logic       framing_error;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [7:0] dv_q[$];
  int         dv_t[$];
  int         fe_n = 0;
  int         viol = 0;
  logic       prev = 1'b0;

  uart_rx #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(SS)) dut (
    .clk           (clk),
    .rst           (rst),
    .rx            (rx),
    .data          (data),
    .data_valid    (data_valid),
    .framing_error (framing_error),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // record pulses and illegal pulse patterns
  always @(negedge clk) begin
    if (!rst) begin
      if (data_valid) begin
        dv_q.push_back(data);
        dv_t.push_back(cyc);
      end
      if (framing_error) fe_n++;
      if ((data_valid && framing_error) ||
          ((data_valid || framing_error) && prev))
        viol++;
    end
    prev = data_valid || framing_error;
  end

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    tick(CPB);
  endtask

  task automatic send_frame(input  logic [7:0] b,
                            input  logic       stop,
                            output int         c0);
    c0 = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
  endtask

  typedef struct {
    logic [7:0] val;
    logic       stop;
    logic [7:0] exp_data;
    logic       exp_dv;
    logic       exp_fe;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int c0, c1, ndv, nfe, gap, nbad;
    logic [7:0] b, last;
    logic st, bsy;
    logic [7:0] exp_q[$];

    tbl[0] = '{8'h61, 1'b1, 8'h61, 1'b1, 1'b0};
    tbl[1] = '{8'h77, 1'b0, 8'h61, 1'b0, 1'b1};
    tbl[2] = '{8'h73, 1'b1, 8'h73, 1'b1, 1'b0};
    tbl[3] = '{8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
    tbl[4] = '{8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    tbl[5] = '{8'hA5, 1'b0, 8'hFF, 1'b0, 1'b1};
    tbl[6] = '{8'h80, 1'b1, 8'h80, 1'b1, 1'b0};

    // reset state
    tick(5);
    check("rst_data", 32'(data), 32'h0);
    check("rst_dv", 32'(data_valid), 32'h0);
    check("rst_fe", 32'(framing_error), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    tick(10);

    // table vectors
    foreach (tbl[i]) begin
      ndv = dv_q.size();
      nfe = fe_n;
      send_frame(tbl[i].val, tbl[i].stop, c0);
      rx = 1'b1;
      tick(30);
      check($sformatf("tbl%0d_dv", i), 32'(dv_q.size() - ndv),
            32'(tbl[i].exp_dv));
      check($sformatf("tbl%0d_fe", i), 32'(fe_n - nfe),
            32'(tbl[i].exp_fe));
      check($sformatf("tbl%0d_data", i), 32'(data),
            32'(tbl[i].exp_data));
      check($sformatf("tbl%0d_busy", i), 32'(busy), 32'h0);
      if (tbl[i].exp_dv && dv_q.size() > ndv)
        check($sformatf("tbl%0d_time", i), 32'(dv_t[$] - c0),
              32'(LAT));
    end

    // glitch start
    ndv = dv_q.size();
    nfe = fe_n;
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    check("glitch_busy_hi", 32'(busy), 32'h1);
    tick(20);
    check("glitch_busy_lo", 32'(busy), 32'h0);
    check("glitch_dv", 32'(dv_q.size() - ndv), 32'h0);
    check("glitch_fe", 32'(fe_n - nfe), 32'h0);
    check("glitch_data", 32'(data), 32'h80);

    // back-to-back frames
    ndv = dv_q.size();
    send_frame(8'h77, 1'b1, c0);
    send_frame(8'h73, 1'b1, c1);
    rx = 1'b1;
    tick(30);
    check("b2b_count", 32'(dv_q.size() - ndv), 32'h2);
    if (dv_q.size() - ndv == 2) begin
      check("b2b_first", 32'(dv_q[ndv]), 32'h77);
      check("b2b_second", 32'(dv_q[ndv + 1]), 32'h73);
      check("b2b_gap", 32'(dv_t[ndv + 1] - dv_t[ndv]), 32'(10 * CPB));
    end

    // reset during bit 4
    ndv = dv_q.size();
    b = 8'h5A;
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 4; i++) send_bit(b[i]);
    rx = b[4];
    tick(5);
    rst = 1'b1;
    tick(2);
    rx = 1'b1;
    rst = 1'b0;
    tick(30);
    check("mid_rst_dv", 32'(dv_q.size() - ndv), 32'h0);
    check("mid_rst_data", 32'(data), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    send_frame(8'h6B, 1'b1, c0);
    rx = 1'b1;
    tick(30);
    check("after_rst_data", 32'(data), 32'h6B);
    check("after_rst_dv", 32'(dv_q.size() - ndv), 32'h1);

    // line low through and after reset
    rx = 1'b0;
    rst = 1'b1;
    tick(5);
    rst = 1'b0;
    ndv = dv_q.size();
    nfe = fe_n;
    bsy = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (busy) bsy = 1'b1;
    end
    check("low_busy", 32'(bsy), 32'h0);
    check("low_dv", 32'(dv_q.size() - ndv), 32'h0);
    check("low_fe", 32'(fe_n - nfe), 32'h0);
    rx = 1'b1;
    tick(20);
    send_frame(8'h64, 1'b1, c0);
    rx = 1'b1;
    tick(30);
    check("low_then_data", 32'(data), 32'h64);
    check("low_then_dv", 32'(dv_q.size() - ndv), 32'h1);

    // random frames against a last-good-byte model
    ndv = dv_q.size();
    nfe = fe_n;
    nbad = 0;
    last = 8'h64;
    for (int i = 0; i < 30; i++) begin
      b  = 8'($urandom);
      st = ($urandom_range(0, 3) != 0);
      send_frame(b, st, c0);
      rx = 1'b1;
      if (st) begin
        exp_q.push_back(b);
        last = b;
        gap = $urandom_range(0, 3);
        if (gap > 0) tick(gap);
      end else begin
        nbad++;
        tick(25);
      end
    end
    tick(30);
    check("rnd_count", 32'(dv_q.size() - ndv), 32'(exp_q.size()));
    check("rnd_fe", 32'(fe_n - nfe), 32'(nbad));
    check("rnd_data", 32'(data), 32'(last));
    if (dv_q.size() - ndv == exp_q.size())
      foreach (exp_q[i])
        check($sformatf("rnd_byte%0d", i), 32'(dv_q[ndv + i]),
              32'(exp_q[i]));

    check("pulse_rules", 32'(viol), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
